// File: rtl/iir.sv
`timescale 1ns/1ps
// First-order fixed-point IIR de-emphasis filter for the FM demod audio path.
// y[n] = DQ(XC0*x[n]) + DQ(XC1*x[n-1]) + DQ(YC1*y[n-1]), where DQ divides by
// 2**QUANT_BITS and truncates toward zero. The filter takes one sample per
// clock, and dout is the registered y[n] one edge after din is sampled.
module iir #(
   parameter int DATA_WIDTH = 32,
   parameter int QUANT_BITS = 10,
   parameter int XC0        = 178,
   parameter int XC1        = 178,
   parameter int YC1        = -666
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   // Products and DQ terms are carried at twice the sample width.
   localparam int PW = 2 * DATA_WIDTH;

   localparam logic signed [PW-1:0] XC0_W = PW'(XC0);
   localparam logic signed [PW-1:0] XC1_W = PW'(XC1);
   localparam logic signed [PW-1:0] YC1_W = PW'(YC1);
   localparam logic signed [PW-1:0] BIAS  = PW'((1 << QUANT_BITS) - 1);

   logic signed [DATA_WIDTH-1:0] x_n;
   logic signed [DATA_WIDTH-1:0] x_prev;
   logic signed [DATA_WIDTH-1:0] y_prev;
   logic signed [DATA_WIDTH-1:0] y_n;
   logic signed [PW-1:0]         p_x0;
   logic signed [PW-1:0]         p_x1;
   logic signed [PW-1:0]         p_y1;
   logic signed [PW-1:0]         y_full;

   // Divide by 2**QUANT_BITS, truncating toward zero.
   function automatic logic signed [PW-1:0] dq(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] biased;
      // NOTE: adding 2**Q-1 to negatives before the shift gives truncation
      // toward zero; a bare >>> would floor (-6*178/1024 -> -2 instead of -1).
      biased = p[PW-1] ? p + BIAS : p;
      return biased >>> QUANT_BITS;
   endfunction

   assign x_n = din;

   // Widen each operand first so every product is exact at PW bits.
   assign p_x0 = PW'(x_n)    * XC0_W;
   assign p_x1 = PW'(x_prev) * XC1_W;
   assign p_y1 = PW'(y_prev) * YC1_W;

   // Sum the quantised taps, then wrap to the sample width (no saturation).
   assign y_full = dq(p_x0) + dq(p_x1) + dq(p_y1);
   assign y_n    = y_full[DATA_WIDTH-1:0];

   // Filter state: reset clears all history, otherwise advance one sample.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_prev <= '0;
         y_prev <= '0;
      end else begin
         // NOTE: non-blocking so both state registers load from the same
         // pre-edge values; blocking here would feed the new x into y_n.
         x_prev <= x_n;
         y_prev <= y_n;
      end
   end

   // The feedback register already holds the latest registered output.
   assign dout = y_prev;

endmodule

// File: tb/tb_iir.sv
`timescale 1ns/1ps
// Self-checking bench for iir: spec vectors from a table, hand-written
// reset/step sequences, and a randomized stream against a plain-arithmetic
// reference model.
module tb_iir;

   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;

   int n_checks = 0;
   int n_errors = 0;

   iir dut (
      .clock (clock),
      .reset (reset),
      .din   (din),
      .dout  (dout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state: the previous input and output sample.
   int m_xp = 0;
   int m_yp = 0;

   // y = XC0*x/1024 + XC1*xp/1024 + YC1*yp/1024, with integer division
   // (which truncates toward zero), summed wide and then wrapped to 32 bits.
   function automatic int model_step(input logic rst, input int x);
      longint s;
      int     y;
      if (rst) begin
         m_xp = 0;
         m_yp = 0;
         return 0;
      end
      s = (longint'(178) * x) / 1024 + (longint'(178) * m_xp) / 1024
        + (longint'(-666) * m_yp) / 1024;
      y = int'(s[31:0]);
      m_xp = x;
      m_yp = y;
      return y;
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one sample/reset away from the edge, sample dout 1 ns after it.
   task automatic drive(input logic rst, input int x, input int expected, input string name);
      @(negedge clock);
      reset = rst;
      din   = x;
      @(posedge clock);
      #1;
      check(name, $signed(dout), expected);
   endtask

   // Drive one sample and compare against the reference model.
   task automatic drive_model(input logic rst, input int x, input string name);
      int e;
      e = model_step(rst, x);
      drive(rst, x, e, name);
   endtask

   typedef struct {
      logic  rst;
      int    x;
      int    exp;
      string name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      reset = 1'b1;
      din   = '0;

      // Expected values are the worked examples for this filter.
      vecs.push_back('{1'b1,     0,    0, "rst_a"});
      vecs.push_back('{1'b0,  1024,  178, "imp0"});
      vecs.push_back('{1'b0,     0,   63, "imp1"});
      vecs.push_back('{1'b0,     0,  -40, "imp2"});
      vecs.push_back('{1'b0,     0,   26, "imp3"});
      vecs.push_back('{1'b1,     0,    0, "rst_b"});
      vecs.push_back('{1'b0, -1024, -178, "nimp0"});
      vecs.push_back('{1'b0,     0,  -63, "nimp1"});
      vecs.push_back('{1'b0,     0,   40, "nimp2"});
      vecs.push_back('{1'b1,     0,    0, "rst_c"});
      vecs.push_back('{1'b0,     6,    1, "trunc_pos6"});
      vecs.push_back('{1'b1,     0,    0, "rst_d"});
      vecs.push_back('{1'b0,    -6,   -1, "trunc_neg6"});
      vecs.push_back('{1'b1,     0,    0, "rst_e"});
      vecs.push_back('{1'b0,     1,    0, "trunc_one"});
      vecs.push_back('{1'b1,     0,    0, "rst_f"});
      vecs.push_back('{1'b0,  1024,  178, "step0"});
      vecs.push_back('{1'b0,  1024,  241, "step1"});
      vecs.push_back('{1'b0,  1024,  200, "step2"});
      vecs.push_back('{1'b1,  1024,    0, "step_rst"});
      vecs.push_back('{1'b0,  1024,  178, "restart0"});
      vecs.push_back('{1'b0,  1024,  241, "restart1"});

      // Reset state.
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", $signed(dout), 0);

      // Table-driven vectors.
      foreach (vecs[i]) drive(vecs[i].rst, vecs[i].x, vecs[i].exp, vecs[i].name);

      // Long step: must track the model while it settles, without drift.
      void'(model_step(1'b1, 0));
      drive(1'b1, 0, 0, "long_step_rst");
      for (int i = 0; i < 40; i++) drive_model(1'b0, 1024, $sformatf("long_step%0d", i));

      // Mid-stream reset while random audio is flowing; history must vanish.
      for (int i = 0; i < 5; i++) drive_model(1'b0, $urandom_range(0, 200000) - 100000, $sformatf("pre_rst%0d", i));
      drive_model(1'b1, 12345, "mid_rst");
      drive_model(1'b0, 1024, "post_rst0");
      drive_model(1'b0, 1024, "post_rst1");

      // Full-scale inputs exercise wide products and the output wrap.
      drive_model(1'b0, 32'h7fffffff, "max_pos");
      drive_model(1'b0, 32'h80000000, "max_neg");
      drive_model(1'b0, 32'h80000000, "max_neg2");
      drive_model(1'b0, 32'h7fffffff, "max_pos2");

      // Streaming regression: 100 consecutive samples, one per clock.
      void'(model_step(1'b1, 0));
      drive(1'b1, 0, 0, "stream_rst");
      for (int i = 0; i < 100; i++) begin
         int x;
         if (i % 17 == 16) x = int'($urandom);
         else              x = int'($urandom_range(0, 2000000)) - 1000000;
         drive_model(1'b0, x, $sformatf("stream%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
